// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side line signals around cache_arbiter.
// The slave view belongs to the arbiter; the master view belongs to the caches/memory.
interface cache_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_addr;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_addr;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic [15:0]       i_count;
    logic [15:0]       d_count;

    modport slave (
        input  i_pmem_read, i_pmem_addr, d_pmem_read, d_pmem_write, d_pmem_addr,
               d_pmem_wdata, pmem_rdata, pmem_resp,
        output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
               pmem_read, pmem_write, pmem_addr, pmem_wdata, i_count, d_count
    );

    modport master (
        output i_pmem_read, i_pmem_addr, d_pmem_read, d_pmem_write, d_pmem_addr,
               d_pmem_wdata, pmem_rdata, pmem_resp,
        input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
               pmem_read, pmem_write, pmem_addr, pmem_wdata, i_count, d_count
    );
endinterface

// File: rtl/cache_arbiter.sv
// Serializes I-cache fills and D-cache fills/write-backs onto one memory line port,
// alternating priority on contention, with saturating per-side completion counters.
module cache_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int OFF_W  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cache_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2} state_t;

    state_t      r_state, w_next;
    logic        r_last_grant;
    logic [15:0] r_i_count, r_d_count;

    logic w_i_req, w_d_req, w_i_done, w_d_done;
    logic w_unused;

    assign w_i_req  = bus.i_pmem_read;
    assign w_d_req  = bus.d_pmem_read | bus.d_pmem_write;
    assign w_i_done = (r_state == SERVE_I) & bus.pmem_resp;
    assign w_d_done = (r_state == SERVE_D) & bus.pmem_resp;
    assign w_unused = ^{bus.i_pmem_addr[OFF_W-1:0], bus.d_pmem_addr[OFF_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_i_count    <= '0;
            r_d_count    <= '0;
        end else begin
            r_state <= w_next;
            if (w_i_done) begin
                r_last_grant <= 1'b0;
                if (r_i_count != 16'hFFFF) r_i_count <= r_i_count + 16'd1;
            end
            if (w_d_done) begin
                r_last_grant <= 1'b1;
                if (r_d_count != 16'hFFFF) r_d_count <= r_d_count + 16'd1;
            end
        end
    end

    // A tie goes to whichever side was not served last.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) w_next = r_last_grant ? SERVE_I : SERVE_D;
                else if (w_i_req)       w_next = SERVE_I;
                else if (w_d_req)       w_next = SERVE_D;
            end
            SERVE_I: if (bus.pmem_resp) w_next = IDLE;
            SERVE_D: if (bus.pmem_resp) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.pmem_addr  = '0;
        bus.pmem_wdata = '0;
        case (r_state)
            SERVE_I: begin
                bus.pmem_read = 1'b1;
                bus.pmem_addr = {bus.i_pmem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
            SERVE_D: begin
                // Write wins if a malformed request asserts both.
                bus.pmem_read  = bus.d_pmem_read & ~bus.d_pmem_write;
                bus.pmem_write = bus.d_pmem_write;
                bus.pmem_addr  = {bus.d_pmem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                bus.pmem_wdata = bus.d_pmem_wdata;
            end
            default: ;
        endcase
    end

    assign bus.i_pmem_resp  = w_i_done;
    assign bus.d_pmem_resp  = w_d_done;
    assign bus.i_pmem_rdata = bus.pmem_rdata;
    assign bus.d_pmem_rdata = bus.pmem_rdata;
    assign bus.i_count      = r_i_count;
    assign bus.d_count      = r_d_count;
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: memory side is driven by hand, expectations are constants.
module tb_cache_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    cache_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();

    cache_arbiter #(.ADDR_W(16), .LINE_W(128), .OFF_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered in IDLE with both sides pending; serves one transaction and its idle turnaround.
    task automatic grant_expect(input string tag, input logic exp_d);
        tick;
        check({tag, "_addr"}, bus.pmem_addr, exp_d ? 16'h2000 : 16'h1000);
        bus.pmem_resp = 1'b1;
        #1;
        check({tag, "_iresp"}, bus.i_pmem_resp, !exp_d);
        check({tag, "_dresp"}, bus.d_pmem_resp, exp_d);
        tick;
        bus.pmem_resp = 1'b0;
        #1;
        check({tag, "_idle"}, {bus.pmem_read, bus.pmem_write}, 2'b00);
    endtask

    // One I-cache fill from IDLE with nothing else pending.
    task automatic i_fill;
        bus.i_pmem_read = 1'b1;
        tick;
        bus.pmem_resp = 1'b1;
        #1;
        check("sat_iresp", bus.i_pmem_resp, 1'b1);
        tick;
        bus.pmem_resp   = 1'b0;
        bus.i_pmem_read = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_pmem_read  = 1'b0;
        bus.i_pmem_addr  = '0;
        bus.d_pmem_read  = 1'b0;
        bus.d_pmem_write = 1'b0;
        bus.d_pmem_addr  = '0;
        bus.d_pmem_wdata = '0;
        bus.pmem_rdata   = '0;
        bus.pmem_resp    = 1'b1;
        #3;
        check("rst_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
        check("rst_resps", {bus.i_pmem_resp, bus.d_pmem_resp}, 2'b00);
        check("rst_counts", {bus.i_count, bus.d_count}, 32'h0);
        tick;
        bus.pmem_resp = 1'b0;
        rst_n = 1'b1;

        // 1: single I fill
        tick;
        bus.i_pmem_read = 1'b1;
        bus.i_pmem_addr = 16'h1236;
        #1;
        check("t1_lat0", bus.pmem_read, 1'b0);
        tick;
        check("t1_read", {bus.pmem_read, bus.pmem_write}, 2'b10);
        check("t1_addr", bus.pmem_addr, 16'h1230);
        tick;
        tick;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = {16{8'hA5}};
        #1;
        check("t1_iresp", bus.i_pmem_resp, 1'b1);
        check("t1_dresp", bus.d_pmem_resp, 1'b0);
        check("t1_rdata", bus.i_pmem_rdata, {16{8'hA5}});
        tick;
        bus.pmem_resp   = 1'b0;
        bus.i_pmem_read = 1'b0;
        #1;
        check("t1_icount", bus.i_count, 16'd1);
        check("t1_pulse", bus.i_pmem_resp, 1'b0);

        // 2: D write-back
        bus.d_pmem_write = 1'b1;
        bus.d_pmem_addr  = 16'h8010;
        bus.d_pmem_wdata = 128'h0123456789ABCDEF_FEDCBA9876543210;
        tick;
        check("t2_strobes", {bus.pmem_read, bus.pmem_write}, 2'b01);
        check("t2_addr", bus.pmem_addr, 16'h8010);
        check("t2_wdata", bus.pmem_wdata, 128'h0123456789ABCDEF_FEDCBA9876543210);
        bus.pmem_resp = 1'b1;
        #1;
        check("t2_dresp", bus.d_pmem_resp, 1'b1);
        check("t2_iresp", bus.i_pmem_resp, 1'b0);
        tick;
        bus.pmem_resp    = 1'b0;
        bus.d_pmem_write = 1'b0;
        #1;
        check("t2_dcount", bus.d_count, 16'd1);

        // 3: contention after reset, strict alternation
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.i_pmem_read = 1'b1;
        bus.i_pmem_addr = 16'h1000;
        bus.d_pmem_read = 1'b1;
        bus.d_pmem_addr = 16'h2000;
        grant_expect("t3_g0", 1'b0);
        grant_expect("t3_g1", 1'b1);
        grant_expect("t3_g2", 1'b0);
        grant_expect("t3_g3", 1'b1);
        check("t3_counts", {bus.i_count, bus.d_count}, {16'd2, 16'd2});

        // 4: illegal read+write on D
        bus.i_pmem_read  = 1'b0;
        bus.d_pmem_write = 1'b1;
        bus.d_pmem_addr  = 16'h3005;
        tick;
        check("t4_strobes", {bus.pmem_read, bus.pmem_write}, 2'b01);
        check("t4_addr", bus.pmem_addr, 16'h3000);

        // 5: reset mid SERVE_D
        bus.pmem_resp = 1'b1;
        rst_n = 1'b0;
        #1;
        check("t5_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
        check("t5_dresp", bus.d_pmem_resp, 1'b0);
        check("t5_dcount", bus.d_count, 16'd0);
        bus.pmem_resp    = 1'b0;
        bus.d_pmem_write = 1'b0;
        bus.d_pmem_read  = 1'b1;
        bus.d_pmem_addr  = 16'h2000;
        bus.i_pmem_read  = 1'b1;
        #1;
        rst_n = 1'b1;
        tick;
        check("t5_grant", {bus.pmem_read, bus.pmem_addr}, {1'b1, 16'h1000});
        bus.pmem_resp = 1'b1;
        #1;
        check("t5_iresp", bus.i_pmem_resp, 1'b1);
        tick;
        bus.pmem_resp   = 1'b0;
        bus.i_pmem_read = 1'b0;
        bus.d_pmem_read = 1'b0;
        #1;

        // 6: stray resp in IDLE, then saturation
        bus.pmem_resp = 1'b1;
        #1;
        check("t6_stray", {bus.i_pmem_resp, bus.d_pmem_resp}, 2'b00);
        tick;
        bus.pmem_resp = 1'b0;
        check("t6_counts", {bus.i_count, bus.d_count}, {16'd1, 16'd0});
        force dut.r_i_count = 16'hFFFE;
        #1;
        release dut.r_i_count;
        #1;
        i_fill;
        check("t6_to_max", bus.i_count, 16'hFFFF);
        i_fill;
        check("t6_sat", bus.i_count, 16'hFFFF);
        check("t6_dcount", bus.d_count, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
